// File: rtl/counter_pkg.sv
// counter_pkg: shared constants and helpers for the LED counter core.
// Provides terminal-mode and direction encodings plus a constant-foldable clog2.
package counter_pkg;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/input_sync.sv
// input_sync: STAGES-flop synchroniser for one asynchronous input bit.
// Ports: clock_i clock, reset_n_i async active-low reset (chain clears to 0),
//        d_i raw asynchronous input, q_o synchronised output.
module input_sync #(
    parameter int STAGES = 2
) (
    input  logic clock_i,
    input  logic reset_n_i,
    input  logic d_i,
    output logic q_o
);
    logic [STAGES-1:0] chain;

    always_ff @(posedge clock_i or negedge reset_n_i)
        if (!reset_n_i) chain <= '0;
        else            chain <= {chain[STAGES-2:0], d_i};

    assign q_o = chain[STAGES-1];
endmodule

// File: rtl/counter_led_core.sv
// counter_led_core: synchronised up/down LED counter with prescaler, wrap/saturate and terminal-count pulse.
// Ports: clock_i clock, reset_n_i async active-low reset,
//        clear_i/count_i/up_i/sat_i raw asynchronous controls (clear, enable, direction, saturate),
//        led_o counter value, tc_o one-cycle pulse after each terminal event.
module counter_led_core
    import counter_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int PRESCALE    = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock_i,
    input  logic             reset_n_i,
    input  logic             clear_i,
    input  logic             count_i,
    input  logic             up_i,
    input  logic             sat_i,
    output logic [WIDTH-1:0] led_o,
    output logic             tc_o
);
    localparam int PW = (clog2(PRESCALE) > 0) ? clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);

    logic          clear_s, count_s, up_s, sat_s;
    logic [PW-1:0] p;
    logic          tick, term, hold;

    input_sync #(.STAGES(SYNC_STAGES)) u_clear (.clock_i(clock_i), .reset_n_i(reset_n_i), .d_i(clear_i), .q_o(clear_s));
    input_sync #(.STAGES(SYNC_STAGES)) u_count (.clock_i(clock_i), .reset_n_i(reset_n_i), .d_i(count_i), .q_o(count_s));
    input_sync #(.STAGES(SYNC_STAGES)) u_up    (.clock_i(clock_i), .reset_n_i(reset_n_i), .d_i(up_i),    .q_o(up_s));
    input_sync #(.STAGES(SYNC_STAGES)) u_sat   (.clock_i(clock_i), .reset_n_i(reset_n_i), .d_i(sat_i),   .q_o(sat_s));

    // Prescaler only advances while enabled, so a paused count resumes mid-period.
    assign tick = count_s && (p == P_LAST);
    assign term = (up_s == DIR_UP) ? &led_o : ~|led_o;
    assign hold = term && (sat_s == MODE_SAT);

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            p     <= '0;
            led_o <= '0;
            tc_o  <= 1'b0;
        end else if (clear_s) begin
            p     <= '0;
            led_o <= '0;
            tc_o  <= 1'b0;
        end else begin
            if (count_s) p <= tick ? '0 : p + PW'(1);
            tc_o <= tick && term;
            // Wrap falls out of modulo arithmetic; only saturation needs an explicit hold.
            if (tick && !hold) led_o <= (up_s == DIR_UP) ? led_o + WIDTH'(1) : led_o - WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_counter_led_core.sv
// tb_counter_led_core: randomized scoreboard bench for two counter_led_core configurations.
module tb_counter_led_core;
    typedef struct {
        int led;
        bit tc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0, cnt = 1'b0, up = 1'b0, sat = 1'b0;
    logic [3:0] led_a;
    logic       tc_a;
    logic [7:0] led_b;
    logic       tc_b;

    exp_t       qa[$], qb[$];
    logic [3:0] h[4];
    int         val[2], ph[2];
    int         tests = 0, fails = 0;

    always #5 clk = ~clk;

    counter_led_core #(.WIDTH(4), .PRESCALE(3), .SYNC_STAGES(2)) dut_a (
        .clock_i(clk), .reset_n_i(rst_n), .clear_i(clr), .count_i(cnt),
        .up_i(up), .sat_i(sat), .led_o(led_a), .tc_o(tc_a));

    counter_led_core #(.WIDTH(8), .PRESCALE(1), .SYNC_STAGES(3)) dut_b (
        .clock_i(clk), .reset_n_i(rst_n), .clear_i(clr), .count_i(cnt),
        .up_i(up), .sat_i(sat), .led_o(led_b), .tc_o(tc_b));

    // Reference: inputs take effect s edges after being sampled; every n enabled
    // cycles the value moves one step modulo 2^w, or stays put at a limit when saturating.
    task automatic model_step(input int d, input int w, input int n, input int s, output exp_t e);
        logic [3:0] x;
        int         modulus;
        bit         tick, at_lim;
        x       = h[s];
        modulus = 1 << w;
        tick    = 0;
        e.tc    = 0;
        if (x[3]) begin
            val[d] = 0;
            ph[d]  = 0;
        end else begin
            if (x[2]) begin
                ph[d]++;
                if (ph[d] == n) begin
                    ph[d] = 0;
                    tick  = 1;
                end
            end
            if (tick) begin
                at_lim = x[1] ? (val[d] == modulus - 1) : (val[d] == 0);
                e.tc   = at_lim;
                if (!(at_lim && x[0])) val[d] = (val[d] + (x[1] ? 1 : -1) + modulus) % modulus;
            end
        end
        e.led = val[d];
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) h[i] = '0;
        val = '{0, 0};
        ph  = '{0, 0};
    endtask

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic drive_cycle(input int p_count, input int p_clear);
        exp_t e;
        @(negedge clk);
        if ($urandom_range(99) < 2) up = ~up;
        if ($urandom_range(99) < 3) sat = ~sat;
        clr = ($urandom_range(99) < p_clear);
        cnt = ($urandom_range(99) < p_count);
        for (int i = 3; i > 0; i--) h[i] = h[i-1];
        h[0] = {clr, cnt, up, sat};
        model_step(0, 4, 3, 2, e);
        qa.push_back(e);
        model_step(1, 8, 1, 3, e);
        qb.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (qa.size() > 0) begin
                e = qa.pop_front();
                tests++;
                if (led_a !== 4'(e.led) || tc_a !== e.tc) begin
                    fails++;
                    $display("FAIL dut_a step: led=%0d tc=%0b expected led=%0d tc=%0b", led_a, tc_a, e.led, e.tc);
                end
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                tests++;
                if (led_b !== 8'(e.led) || tc_b !== e.tc) begin
                    fails++;
                    $display("FAIL dut_b step: led=%0d tc=%0b expected led=%0d tc=%0b", led_b, tc_b, e.led, e.tc);
                end
            end
        end
    end

    initial begin
        model_reset();
        #1;
        check("reset_led_a", int'(led_a), 0);
        check("reset_tc_a", int'(tc_a), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int seg = 0; seg < 5; seg++) begin
            for (int c = 0; c < 400; c++)
                drive_cycle(seg == 2 ? 55 : 95, seg == 3 ? 6 : 1);
            // Asynchronous reset mid-run: outputs must clear without any clock edge.
            @(negedge clk);
            #2;
            rst_n = 1'b0;
            #1;
            check("async_rst_led_a", int'(led_a), 0);
            check("async_rst_tc_a", int'(tc_a), 0);
            check("async_rst_led_b", int'(led_b), 0);
            check("async_rst_tc_b", int'(tc_b), 0);
            clr = 1'b0;
            cnt = 1'b0;
            model_reset();
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
        end
        // Idle after release: with count disabled the value must stay 0.
        for (int c = 0; c < 12; c++) drive_cycle(0, 0);
        @(posedge clk);
        #3;
        check("queue_a_drained", qa.size(), 0);
        check("queue_b_drained", qb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/counter_led_core.md
# counter_led_core

Parametrised successor to the board-level 8-bit LED counter top. Synchronises raw board inputs and runs a WIDTH-bit up/down counter with a programmable prescaler, wrap or saturate mode and a terminal-count pulse. Drives board LEDs directly and sits between FPGA pins and the LED bank in every per-vendor top.

## Interface
- WIDTH, 8, counter/LED width; legal 2..32
- PRESCALE, 1, clock cycles per count step while enabled; legal 1..2^16
- SYNC_STAGES, 2, synchroniser depth per input; legal 2..4
- clock_i  in  1  system clock
- reset_n_i  in  1  reset; one clock, asynchronous, active-low
- clear_i  in  1  synchronous clear request, active-high, asynchronous to clock_i
- count_i  in  1  count enable (level), asynchronous to clock_i
- up_i  in  1  direction: 1 up, 0 down
- sat_i  in  1  terminal behaviour: 0 wrap, 1 saturate
- led_o  out  WIDTH  counter value Q
- tc_o  out  1  one-cycle terminal-count pulse

## Operation
- Reset (reset_n_i=0, async assert): all flops 0 incl. synchroniser chains, prescaler P, Q; led_o=0, tc_o=0. Deassertion must be synchronised at top level.
- Each of clear_i, count_i, up_i, sat_i passes through its own SYNC_STAGES-flop chain -> clear_s, count_s, up_s, sat_s. No other logic uses raw inputs.
- Prescaler P, width max(1,clog2(PRESCALE)): when count_s=1, tick = (P==PRESCALE-1); P <= tick ? 0 : P+1. When count_s=0, P holds and tick=0. PRESCALE=1: tick=count_s every cycle.
- Priority per cycle: clear_s > tick > hold.
- clear_s=1: Q<=0, P<=0, tc_o<=0, regardless of count_s.
- tick, up_s=1: Q==2^WIDTH-1 -> terminal event; Q<=0 if sat_s=0, Q holds if sat_s=1. Else Q<=Q+1.
- tick, up_s=0: Q==0 -> terminal event; Q<=2^WIDTH-1 if sat_s=0, holds if sat_s=1. Else Q<=Q-1.
- tc_o registered: 1 for exactly the cycle after each terminal event, else 0. In saturate mode held at the limit, tc_o pulses once per tick.
- Arithmetic modulo 2^WIDTH; no internal carry beyond WIDTH bits.
- up_s/sat_s changes apply on the next tick; P not reset by them.
- Mid-run count_s drop: P and Q frozen; resuming continues from the frozen P (no phase loss).

## Timing
- Edge 0 = first clock_i edge sampling count_i=1 (others stable): count_s high after edge SYNC_STAGES-1; with PRESCALE=1, led_o first changes after edge SYNC_STAGES, then every edge.
- With PRESCALE=N: first step after edge SYNC_STAGES+N-1, then every N edges.
- clear_i sampled at edge 0: led_o=0 after edge SYNC_STAGES.
- tc_o asserted after the same edge that applies the wrap/hold; led_o and tc_o change together.
- Glitches shorter than one clock period may be missed; no debounce in this block.

## Structure
- counter_pkg: MODE_WRAP=0, MODE_SAT=1, DIR_DOWN=0, DIR_UP=1 constants; clog2 function.
- Sub-module input_sync (parameter STAGES; clock_i, reset_n_i, d_i, q_o), instantiated four times. Prescaler and counter in the core body.
- Vendor tops instantiate counter_led_core with WIDTH=8, map led_o to pins.

## Test plan
- Reset: assert reset_n_i mid-count (Q=5) -> led_o=0, tc_o=0 immediately, no clock needed; stays 0 with count_i=0 after release.
- WIDTH=4, PRESCALE=1, SYNC_STAGES=2, up, wrap: count_i=1 at edge 0 -> led_o=1 after edge 2, 15 after edge 16, 0 after edge 17 with tc_o=1 that cycle only.
- WIDTH=4, PRESCALE=3, down, saturate, start Q=0: led_o stays 0, tc_o pulses once every 3 cycles; switch sat_i=0 -> next tick led_o=15, tc_o=1.
- Pause/resume: PRESCALE=4, drop count_i after 2 cycles into a period, hold 10 cycles, raise -> next step exactly 2 enabled cycles (after sync) later.
- Clear vs tick: clear_i and count_i both high, Q=7 -> led_o=0, tc_o=0, no step that cycle; P restarts from 0.
- Direction flip at WIDTH=8: Q=3 up, set up_i=0 -> after sync, subsequent ticks give 4 (pending) then 3,2,1,0 then 255 with tc_o=1.
